hangman_game_ctrl: RTL

- Sequences one hangman round: loads the secret word, captures one guess per press/release of the go key, and compares it against every letter slot.
- Tracks revealed positions, distinct letters already tried and the miss count, and decides win or loss.
- Sits between the switch/KEY inputs and the display/drawing datapath; its outputs drive the letter unmasking and the hangman drawing stages.

---
 rtl/hangman_pkg.sv | 24 ++
 rtl/hangman_letter_match.sv | 20 ++
 rtl/hangman_game_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared constants, result codes and state encoding for the hangman round controller.
package hangman_pkg;

    localparam int LETTER_W = 5;
    localparam logic [LETTER_W-1:0] BLANK = 5'b11111;
    localparam int ALPHA_SIZE = 26;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_HIT  = 2'd1,
        R_MISS = 2'd2,
        R_NOP  = 2'd3
    } result_t;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        WAIT_RELEASE = 3'd2,
        EVAL         = 3'd3,
        WON          = 3'd4,
        LOST         = 3'd5
    } state_t;

endpackage

// File: rtl/hangman_letter_match.sv
// Compares the latched guess against every letter slot; BLANK slots never match.
module letter_match
    import hangman_pkg::*;
#(
    parameter int WORD_LEN = 5
) (
    input  logic [WORD_LEN*LETTER_W-1:0] word,
    input  logic [LETTER_W-1:0]          guess_r,
    output logic [WORD_LEN-1:0]          hit_vec
);

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            hit_vec[i] = (word[i*LETTER_W +: LETTER_W] == guess_r) &&
                         (word[i*LETTER_W +: LETTER_W] != BLANK);
        end
    end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman round controller: word load, debounced guess capture, evaluation and
// win/loss bookkeeping feeding the unmasking and drawing stages.
//
// state        | meaning
// IDLE         | no word loaded, go ignored
// WAIT_PRESS   | round active, waiting for a go press edge
// WAIT_RELEASE | guess latched, waiting for go to drop
// EVAL         | single cycle applying the latched guess
// WON          | every slot revealed, outputs frozen
// LOST         | miss limit reached, outputs frozen
module hangman_game_ctrl
    import hangman_pkg::*;
#(
    parameter int WORD_LEN   = 5,
    parameter int MAX_MISSES = 6
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         word_load,
    input  logic [WORD_LEN*LETTER_W-1:0] word_in,
    input  logic [LETTER_W-1:0]          guess,
    input  logic                         go,
    output logic [WORD_LEN-1:0]          reveal_mask,
    output logic [2:0]                   miss_count,
    output logic [ALPHA_SIZE-1:0]        guessed_set,
    output logic [1:0]                   last_result,
    output logic                         ready,
    output logic                         win,
    output logic                         lose
);

    state_t                       state;
    logic                         go_q;
    logic [LETTER_W-1:0]          guess_r;
    logic [WORD_LEN*LETTER_W-1:0] word_r;

    logic [WORD_LEN-1:0]   hit_vec;
    logic [WORD_LEN-1:0]   blank_in;
    logic [ALPHA_SIZE-1:0] letter_sel;
    logic                  letter_valid;
    logic                  already_tried;

    logic [WORD_LEN-1:0]   mask_next;
    logic [2:0]            miss_next;
    logic [ALPHA_SIZE-1:0] set_next;
    result_t               res_next;
    state_t                eval_next;

    letter_match #(.WORD_LEN(WORD_LEN)) u_letter_match (
        .word    (word_r),
        .guess_r (guess_r),
        .hit_vec (hit_vec)
    );

    always_comb begin
        blank_in = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            blank_in[i] = (word_in[i*LETTER_W +: LETTER_W] == BLANK);
        end
    end

    // One-hot letter select doubles as the range check: codes above Z select nothing.
    always_comb begin
        letter_sel = '0;
        for (int n = 0; n < ALPHA_SIZE; n++) begin
            letter_sel[n] = (guess_r == LETTER_W'(n));
        end
    end

    assign letter_valid  = |letter_sel;
    assign already_tried = |(letter_sel & guessed_set);

    always_comb begin
        mask_next = reveal_mask;
        miss_next = miss_count;
        set_next  = guessed_set;
        res_next  = R_NOP;
        if (letter_valid && !already_tried) begin
            set_next = guessed_set | letter_sel;
            if (|hit_vec) begin
                mask_next = reveal_mask | hit_vec;
                res_next  = R_HIT;
            end else begin
                miss_next = miss_count + 3'd1;
                res_next  = R_MISS;
            end
        end
        if (&mask_next) begin
            eval_next = WON;
        end else if (miss_next == 3'(MAX_MISSES)) begin
            eval_next = LOST;
        end else begin
            eval_next = WAIT_PRESS;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            go_q        <= 1'b0;
            guess_r     <= '0;
            word_r      <= '0;
            reveal_mask <= '0;
            miss_count  <= '0;
            guessed_set <= '0;
            last_result <= R_NONE;
            ready       <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            go_q <= go;
            if (word_load) begin
                word_r      <= word_in;
                reveal_mask <= blank_in;
                miss_count  <= '0;
                guessed_set <= '0;
                last_result <= R_NONE;
                lose        <= 1'b0;
                if (&blank_in) begin
                    state <= WON;
                    ready <= 1'b0;
                    win   <= 1'b1;
                end else begin
                    state <= WAIT_PRESS;
                    ready <= 1'b1;
                    win   <= 1'b0;
                end
            end else begin
                case (state)
                    WAIT_PRESS: begin
                        if (go && !go_q) begin
                            guess_r <= guess;
                            state   <= WAIT_RELEASE;
                            ready   <= 1'b0;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!go) begin
                            state <= EVAL;
                        end
                    end
                    EVAL: begin
                        reveal_mask <= mask_next;
                        miss_count  <= miss_next;
                        guessed_set <= set_next;
                        last_result <= res_next;
                        state       <= eval_next;
                        ready       <= (eval_next == WAIT_PRESS);
                        win         <= (eval_next == WON);
                        lose        <= (eval_next == LOST);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
